ifu_prefetch: RTL and testbench
===============================

# ifu_prefetch

Parametrised instruction fetch unit with a prefetch queue. It sits between instruction memory and the decode stage. It keeps a fetch PC and issues one memory request at a time over a req/ack handshake. Returned words are queued with their PCs in a DEPTH-entry FIFO, and decode drains the FIFO through a valid/ready interface. A redirect (branch/jump) flushes the queue, restarts fetch at the new PC, and discards any response still in flight.

## Interface
- XLEN, 32, width of PC, address and instruction word
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- RESET_PC, 0, fetch PC after reset
- PC_STEP, 4, PC increment per fetched word

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- run_en  in  1  allows new fetch requests; an outstanding request always completes
- redirect_valid  in  1  load redirect_pc and flush; independent of run_en
- redirect_pc  in  XLEN  new fetch PC
- mem_req  out  1  request valid; held high until mem_ack
- mem_addr  out  XLEN  request address; stable while mem_req=1
- mem_ack  in  1  mem_rdata valid this cycle; completes the request
- mem_rdata  in  XLEN  fetched word
- ir_valid  out  1  FIFO head valid
- ir  out  XLEN  head instruction; 0 when ir_valid=0
- ir_pc  out  XLEN  PC of head instruction; 0 when ir_valid=0
- ir_ready  in  1  decode consumes head when ir_valid & ir_ready

## Operation
- Registers:
  - pc_q: next address to fetch.
  - addr_q: drives mem_addr.
  - FSM state.
  - FIFO of {pc, ir}.
- FSM states: IDLE (mem_req=0), REQ (mem_req=1), DROP (mem_req=1; response will be discarded).
- can_issue = run_en & (count_after_edge < DEPTH). With a single outstanding request, a returning response always has room.
- IDLE:
  - redirect → pc_q←redirect_pc, flush, stay IDLE this cycle.
  - Otherwise, if can_issue → REQ, addr_q←pc_q.
- REQ, no ack:
  - No redirect → hold state and addr_q.
  - Redirect → DROP, pc_q←redirect_pc, flush; addr_q unchanged.
- REQ with ack, no redirect:
  - Push {addr_q, mem_rdata}; pc_q←pc_q+PC_STEP.
  - Next state is REQ with addr_q←pc_q+PC_STEP if can_issue, else IDLE.
- REQ with ack and redirect: data discarded, pc_q←redirect_pc, flush; next REQ with addr_q←redirect_pc if run_en, else IDLE.
- DROP:
  - Redirect → pc_q←redirect_pc again, flush.
  - On ack: response discarded; next REQ with addr_q←(updated) pc_q if run_en, else IDLE.
- Pop on ir_valid & ir_ready. Push and pop in the same cycle leave count unchanged.
- Flush overrides pop and push in the same cycle.
- Arithmetic: pc_q+PC_STEP is modulo 2^XLEN and wraps silently (all-ones region → 0).

## Timing
- Reset values:
  - state IDLE, pc_q=RESET_PC, addr_q=RESET_PC.
  - FIFO empty.
  - mem_req=0, ir_valid=0, ir=0, ir_pc=0.
- Reset asserted mid-request abandons it immediately: mem_req drops asynchronously, and any later ack is ignored in IDLE.
- mem_req and mem_addr are registered-state outputs with no combinational path from inputs. ir, ir_pc and ir_valid come from the FIFO head with no combinational path from mem_rdata.
- Latency: run_en high in IDLE at edge N → mem_req=1 in cycle N+1. An ack in cycle N+1 → ir_valid=1 in cycle N+2.
- Zero-wait memory with ir_ready=1 sustains one instruction per cycle.
- Redirect at edge N → ir_valid=0 from cycle N+1 until the first word from redirect_pc is pushed.

## Structure
- Package ifu_pkg holds:
  - the FSM state enum {IDLE, REQ, DROP};
  - the entry struct {pc, ir}, parametrised via XLEN localparam defaults;
  - DEPTH and RESET_PC defaults.
- Sub-module ifu_fetch_fifo is a synchronous FIFO with flush, push, pop and count, and has no fall-through. The top holds only the FSM and the PC registers.

## Test plan
- Reset then run_en=1, zero-wait ack, ir_ready=1 → mem_addr 0,4,8,… on consecutive cycles; ir_pc 0,4,8,… one per cycle starting 2 cycles after run_en.
- ir_ready=0, DEPTH=4, zero-wait memory → exactly 4 words queued, mem_req=0 afterwards, count=4. Raising ir_ready drains 0,4,8,C and fetch resumes at 0x10.
- Redirect to 0x200 while REQ for 0x8 awaits ack (ack 3 cycles later) → mem_addr stays 0x8 until ack, word discarded, next request 0x200, first ir_pc=0x200.
- Redirect to 0x40 in the same cycle as ack and pop with 2 entries queued → FIFO empty next cycle, next mem_addr=0x40, no stale entry ever presented.
- run_en dropped while REQ outstanding → ack accepted and pushed, then IDLE, mem_req=0 until run_en returns.
- pc_q=0xFFFFFFFC fetch → next mem_addr=0x00000000. Reset asserted mid-request → mem_req=0 and ir_valid=0 immediately.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction fetch unit and its prefetch queue.
package ifu_pkg;

    localparam int unsigned           IFU_XLEN     = 32;
    localparam int unsigned           IFU_DEPTH    = 4;
    localparam logic [IFU_XLEN-1:0]   IFU_RESET_PC = '0;
    localparam int unsigned           IFU_PC_STEP  = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } fetch_state_e;

    typedef struct packed {
        logic [IFU_XLEN-1:0] pc;
        logic [IFU_XLEN-1:0] ir;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Registered-head synchronous FIFO for fetched {pc, ir} entries; flush wins over push and pop.
module ifu_fetch_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned WIDTH = $bits(fetch_entry_t),
    parameter int unsigned DEPTH = IFU_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & (count_q != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: one outstanding req/ack fetch, prefetch queue, redirect with drop.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int unsigned     XLEN     = IFU_XLEN,
    parameter int unsigned     DEPTH    = IFU_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC),
    parameter int unsigned     PC_STEP  = IFU_PC_STEP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            ir_valid,
    output logic [XLEN-1:0] ir,
    output logic [XLEN-1:0] ir_pc,
    input  logic            ir_ready
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   pc_inc;
    logic [AW:0]       count;
    logic [AW:0]       count_next;
    logic              push, pop, flush, can_issue;
    logic [2*XLEN-1:0] head;

    assign pc_inc = pc_q + XLEN'(PC_STEP);
    assign flush  = redirect_valid;
    assign push   = (state_q == REQ) & mem_ack & ~redirect_valid;
    assign pop    = ir_valid & ir_ready;

    // Occupancy after this edge decides whether another request still has a guaranteed slot.
    always_comb begin
        count_next = '0;
        if (!flush) begin
            count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign can_issue = run_en & (count_next < (AW+1)'(DEPTH));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (can_issue) begin
                    state_d = REQ;
                    addr_d  = pc_q;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    pc_d    = redirect_valid ? redirect_pc : pc_inc;
                    state_d = IDLE;
                    if (redirect_valid ? run_en : can_issue) begin
                        state_d = REQ;
                        addr_d  = pc_d;
                    end
                end else if (redirect_valid) begin
                    state_d = DROP;
                    pc_d    = redirect_pc;
                end
            end
            DROP: begin
                if (redirect_valid) pc_d = redirect_pc;
                if (mem_ack) begin
                    state_d = run_en ? REQ : IDLE;
                    if (run_en) addr_d = pc_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    ifu_fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .wdata ({addr_q, mem_rdata}),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

    assign mem_req  = (state_q != IDLE);
    assign mem_addr = addr_q;
    assign ir_valid = (count != '0);
    assign ir       = ir_valid ? head[XLEN-1:0] : '0;
    assign ir_pc    = ir_valid ? head[2*XLEN-1:XLEN] : '0;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed and randomized bench for ifu_prefetch with a stream-level reference model.
module tb_ifu_prefetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_ready;

    int total = 0;
    int bad = 0;
    int mem_lat = 0;
    int wait_cnt;
    int n;
    int consumed = 0;
    logic        sb_on = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] exp_pc = '0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
    endfunction

    // Memory model: acks after mem_lat waiting cycles, data is a fixed function of the address.
    always @(posedge clk or posedge reset) begin
        if (reset) wait_cnt <= 0;
        else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end
    assign mem_ack   = mem_req && (wait_cnt >= mem_lat);
    assign mem_rdata = word_at(mem_addr);

    ifu_prefetch dut (
        .clk            (clk),
        .reset          (reset),
        .run_en         (run_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .ir_valid       (ir_valid),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .ir_ready       (ir_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Decode sees a contiguous PC stream restarting at each redirect target.
    task automatic scoreboard();
        if (prev_hold) begin
            chk("req_held", {31'b0, mem_req}, 32'd1);
            chk("addr_stable", mem_addr, prev_addr);
        end
        prev_hold = mem_req && !mem_ack;
        prev_addr = mem_addr;
        if (!ir_valid) begin
            chk("empty_head_zero", ir | ir_pc, 32'd0);
        end else if (ir_ready && !redirect_valid) begin
            chk("stream_pc", ir_pc, exp_pc);
            chk("stream_word", ir, word_at(exp_pc));
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
        if (redirect_valid) exp_pc = redirect_pc;
    endtask

    task automatic tick();
        @(negedge clk);
        if (sb_on) scoreboard();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; run_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        ir_ready = 1'b0; mem_lat = 0;
        tick();
        reset = 1'b0;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_ir_pc", ir_pc, 32'd0);

        // Zero-wait streaming.
        run_en = 1'b1; ir_ready = 1'b1;
        tick();
        chk("first_req", {31'b0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'd0);
        chk("first_ir_valid", {31'b0, ir_valid}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("stream_addr", mem_addr, 32'(4 * (i + 1)));
            chk("stream_ir_pc", ir_pc, 32'(4 * i));
            chk("stream_ir", ir, word_at(32'(4 * i)));
        end

        // Asynchronous reset mid-request.
        reset = 1'b1;
        #1;
        chk("async_rst_req", {31'b0, mem_req}, 32'd0);
        chk("async_rst_valid", {31'b0, ir_valid}, 32'd0);
        tick();
        reset = 1'b0; run_en = 1'b1; ir_ready = 1'b0;

        // Fill the queue with decode stalled.
        repeat (5) tick();
        chk("full_req_off", {31'b0, mem_req}, 32'd0);
        chk("full_head", ir_pc, 32'd0);
        repeat (2) tick();
        chk("full_still_idle", {31'b0, mem_req}, 32'd0);
        chk("full_still_valid", {31'b0, ir_valid}, 32'd1);
        ir_ready = 1'b1;
        tick();
        chk("drain_pc1", ir_pc, 32'h4);
        chk("resume_req", {31'b0, mem_req}, 32'd1);
        chk("resume_addr", mem_addr, 32'h10);
        tick();
        chk("drain_pc2", ir_pc, 32'h8);
        tick();
        chk("drain_pc3", ir_pc, 32'hC);
        tick();
        chk("drain_pc4", ir_pc, 32'h10);

        // Redirect while a slow request is outstanding.
        reset = 1'b1;
        tick();
        reset = 1'b0; mem_lat = 3; run_en = 1'b1; ir_ready = 1'b1;
        n = 0;
        while (!(mem_req && mem_addr == 32'h8) && n < 60) begin
            tick();
            n++;
        end
        chk("wait_req8", {31'b0, n < 60}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drop_addr", mem_addr, 32'h8);
            chk("drop_req", {31'b0, mem_req}, 32'd1);
            chk("drop_no_valid", {31'b0, ir_valid}, 32'd0);
            tick();
        end
        chk("redir_addr", mem_addr, 32'h200);
        chk("redir_no_valid", {31'b0, ir_valid}, 32'd0);
        mem_lat = 0;
        tick();
        chk("redir_first_pc", ir_pc, 32'h200);
        chk("redir_first_ir", ir, word_at(32'h200));
        chk("redir_next_addr", mem_addr, 32'h204);

        // Redirect coinciding with ack and pop, two entries queued.
        ir_ready = 1'b0;
        tick();
        chk("two_queued_head", ir_pc, 32'h200);
        ir_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk("flush_empty", {31'b0, ir_valid}, 32'd0);
        chk("flush_addr", mem_addr, 32'h40);
        chk("flush_req", {31'b0, mem_req}, 32'd1);
        tick();
        chk("flush_first_pc", ir_pc, 32'h40);
        chk("flush_next_addr", mem_addr, 32'h44);

        // run_en dropped with a request outstanding.
        mem_lat = 2; run_en = 1'b0;
        tick();
        chk("stop_req1", {31'b0, mem_req}, 32'd1);
        chk("stop_addr1", mem_addr, 32'h44);
        tick();
        chk("stop_req2", {31'b0, mem_req}, 32'd1);
        tick();
        chk("stop_idle", {31'b0, mem_req}, 32'd0);
        chk("stop_pushed", ir_pc, 32'h44);
        tick();
        chk("stop_stays_idle", {31'b0, mem_req}, 32'd0);
        chk("stop_drained", {31'b0, ir_valid}, 32'd0);
        run_en = 1'b1; mem_lat = 0;
        tick();
        chk("restart_addr", mem_addr, 32'h48);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_req_addr", mem_addr, 32'hFFFF_FFFC);
        chk("wrap_flushed", {31'b0, ir_valid}, 32'd0);
        tick();
        chk("wrap_next_addr", mem_addr, 32'h0);
        chk("wrap_top_pc", ir_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_zero_pc", ir_pc, 32'h0);
        chk("wrap_zero_ir", ir, word_at(32'h0));

        reset = 1'b1;
        #1;
        chk("async_rst2_req", {31'b0, mem_req}, 32'd0);
        chk("async_rst2_pc", ir_pc, 32'd0);
        tick();
        reset = 1'b0;
        exp_pc = '0; prev_hold = 1'b0; sb_on = 1'b1;

        // Randomized traffic against the stream model.
        for (int c = 0; c < 3000; c++) begin
            run_en         = ($urandom_range(0, 9) != 0);
            ir_ready       = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 29) == 0);
            redirect_pc    = $urandom & 32'hFFFF_FFFC;
            mem_lat        = $urandom_range(0, 3);
            tick();
        end
        sb_on = 1'b0;
        chk("progress", {31'b0, consumed > 200}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
